// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and constants for the multi-cycle signed
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // Sequencer states of the multiply/divide unit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Radix-4 Booth retires two multiplier bits per step; division one bit
  localparam int MULT_STEPS = 16;
  localparam int DIV_STEPS  = 32;

  // Step counter must reach DIV_STEPS-1
  localparam int CNT_W = 5;

  // Most negative 32-bit value, needed for the INT_MIN / -1 overflow case
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_unit_booth_radix4_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_step
// Description : Combinational radix-4 modified Booth recoder. Maps a 3-bit
//               window {b[i+1], b[i], b[i-1]} of the multiplier to the signed
//               partial-product addend 0, +M, +2M, -M or -2M, two bits wider
//               than the multiplicand so +/-2M is representable.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_step #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] addend
);

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] m2_ext;

  // Sign-extended multiplicand and its double
  assign m_ext  = {{2{mcand[WIDTH-1]}}, mcand};
  assign m2_ext = {mcand[WIDTH-1], mcand, 1'b0};

  // Booth digit decode: window value selects the addend
  always_comb begin
    addend = '0;
    case (window)
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m2_ext;
      3'b100:         addend = (~m2_ext) + (WIDTH+2)'(1);
      3'b101, 3'b110: addend = (~m_ext) + (WIDTH+2)'(1);
      default:        addend = '0;
    endcase
  end

endmodule : booth_radix4_step
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_unit
// Description : Multi-cycle signed multiply/divide unit. A one-cycle
//               ctrl_mult / ctrl_div pulse latches the operands; the unit
//               iterates (radix-4 Booth multiply, 17-cycle latency, or
//               non-restoring divide, 33-cycle latency) while busy stalls the
//               pipeline, then pulses result_rdy with data_result and
//               data_exception.
//               Optional build macro: MULTDIV_EARLY_DIV0_EN - a divide by
//               zero finishes one cycle after the start instead of running
//               the full divide sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             result_rdy,
  output logic             busy
);

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam logic EARLY_DIV0 = 1'b1;
`else
  localparam logic EARLY_DIV0 = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  // Sequencer
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_mult;
  logic             start_div;
  logic             operand_b_zero;
  logic             retire;

  // Booth datapath: {acc, mplr, guard} shifts right two bits per step
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplr;
  logic             guard;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] psum;

  // Non-restoring divider datapath on operand magnitudes
  logic [WIDTH+1:0] rem;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] rem_nxt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             is_div;
  logic             neg_q;
  logic             div0;
  logic             div_ovf;

  // Final result selection, registered out of DONE
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;

  // Simultaneous pulses are treated as no start at all
  assign start_mult     = ctrl_mult & ~ctrl_div;
  assign start_div      = ctrl_div & ~ctrl_mult;
  assign operand_b_zero = (data_operandB == '0);

  // DONE hands over to IDLE without a restart: this is the retiring edge
  assign retire = (state == DONE) && (state_nxt == IDLE);

  assign mag_a = data_operandA[WIDTH-1] ? ((~data_operandA) + WIDTH'(1)) : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? ((~data_operandB) + WIDTH'(1)) : data_operandB;

  booth_radix4_step #(
    .WIDTH (WIDTH)
  ) u_booth (
    .window (({mplr[1:0], guard})),
    .mcand  (mcand),
    .addend (addend)
  );

  assign psum = {acc[WIDTH], acc} + addend;

  // Remainder sign picks subtract (non-negative) or add-back (negative)
  assign rem_shift = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_nxt   = rem[WIDTH+1] ? (rem_shift + {2'b00, dvsr})
                                  : (rem_shift - {2'b00, dvsr});

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a valid start wins from any state
  always_comb begin
    state_nxt = state;
    if (start_mult) begin
      state_nxt = MULT;
    end else if (start_div) begin
      state_nxt = (EARLY_DIV0 && operand_b_zero) ? DONE : DIV;
    end else begin
      case (state)
        MULT:    if (cnt == MULT_LAST) state_nxt = DONE;
        DIV:     if (cnt == DIV_LAST)  state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture and one iteration step per cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      mplr    <= '0;
      guard   <= 1'b0;
      mcand   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      div0    <= 1'b0;
      div_ovf <= 1'b0;
    end else if (start_mult) begin
      cnt    <= '0;
      acc    <= '0;
      mplr   <= data_operandA;
      guard  <= 1'b0;
      mcand  <= data_operandB;
      is_div <= 1'b0;
    end else if (start_div) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= mag_a;
      dvsr    <= mag_b;
      is_div  <= 1'b1;
      neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0    <= operand_b_zero;
      div_ovf <= (data_operandA == WIDTH'(INT_MIN)) && (data_operandB == '1);
    end else begin
      case (state)
        MULT: begin
          acc   <= {psum[WIDTH+1], psum[WIDTH+1:2]};
          mplr  <= {psum[1:0], mplr[WIDTH-1:2]};
          guard <= mplr[1];
          cnt   <= cnt + CNT_W'(1);
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and exception from the finished datapath, with divide special cases
  always_comb begin
    fin_result = mplr;
    fin_exc    = (acc[WIDTH-1:0] != {WIDTH{mplr[WIDTH-1]}});
    if (is_div) begin
      if (div0) begin
        fin_result = '0;
        fin_exc    = 1'b1;
      end else if (div_ovf) begin
        fin_result = WIDTH'(INT_MIN);
        fin_exc    = 1'b1;
      end else begin
        fin_result = neg_q ? ((~quo) + WIDTH'(1)) : quo;
        fin_exc    = 1'b0;
      end
    end
  end

  // Registered outputs; busy covers the completion cycle as well
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      result_rdy     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy       <= (state_nxt != IDLE) || (state == DONE);
      result_rdy <= retire;
      if (retire) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
      end
    end
  end

endmodule : multdiv_unit
`default_nettype wire
